// File: rtl/crossbar_port_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : crossbar_port_scheduler
// Brief    : Per-output round-robin source arbitration, fixed transfer hold,
//            and valid/ready completion delivery for the crossbar datapath.
// Revision : 1.0  initial release
// ============================================================================
module crossbar_port_scheduler #(
    parameter  int NUM_PROC    = 4,
    parameter  int XFER_CYCLES = 4,
    localparam int IDW         = $clog2(NUM_PROC),
    localparam int FW          = $clog2(NUM_PROC + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_PROC-1:0]          req_valid,
    input  logic [NUM_PROC-1:0][IDW-1:0] req_dest,
    output logic [NUM_PROC-1:0]          grant,
    output logic [NUM_PROC-1:0][IDW-1:0] out_sel,
    output logic [NUM_PROC-1:0]          out_valid,
    output logic [NUM_PROC-1:0][IDW-1:0] out_src,
    input  logic [NUM_PROC-1:0]          out_ready,
    output logic [NUM_PROC-1:0]          port_busy,
    output logic [FW-1:0]                in_flight
);

    localparam int              CW       = (XFER_CYCLES > 1) ? $clog2(XFER_CYCLES) : 1;
    localparam logic [CW-1:0]   CNT_LOAD = CW'(XFER_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_XFER    = 2'd1,
        ST_DELIVER = 2'd2
    } state_t;

    logic [NUM_PROC-1:0]               r_grant;
    logic [NUM_PROC-1:0]               w_grant_nxt;
    logic [NUM_PROC-1:0][NUM_PROC-1:0] w_port_grant;
    logic [FW-1:0]                     w_in_flight;

    for (genvar d = 0; d < NUM_PROC; d++) begin : g_port
        state_t              r_state;
        state_t              w_state_nxt;
        logic [CW-1:0]       r_cnt;
        logic [CW-1:0]       w_cnt_nxt;
        logic [IDW-1:0]      r_ptr;
        logic [IDW-1:0]      w_ptr_nxt;
        logic [IDW-1:0]      r_sel;
        logic [IDW-1:0]      w_sel_nxt;
        logic [IDW-1:0]      r_src;
        logic [IDW-1:0]      w_src_nxt;
        logic                r_oval;
        logic                w_oval_nxt;
        logic [NUM_PROC-1:0] w_elig;
        logic [NUM_PROC-1:0] w_gnt;
        logic                w_found;
        logic [IDW-1:0]      w_pick;

        // A source granted last cycle still shows its old head; mask it out.
        always_comb begin
            w_elig = '0;
            for (int s = 0; s < NUM_PROC; s++) begin
                w_elig[s] = req_valid[s] && (req_dest[s] == IDW'(d)) && !r_grant[s];
            end
        end

        always_comb begin
            w_found = 1'b0;
            w_pick  = r_ptr;
            for (int i = 0; i < NUM_PROC; i++) begin
                if (!w_found && w_elig[r_ptr + IDW'(i)]) begin
                    w_found = 1'b1;
                    w_pick  = r_ptr + IDW'(i);
                end
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_ptr_nxt   = r_ptr;
            w_sel_nxt   = r_sel;
            w_src_nxt   = r_src;
            w_oval_nxt  = r_oval;
            w_gnt       = '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        w_gnt[w_pick] = 1'b1;
                        w_sel_nxt     = w_pick;
                        w_cnt_nxt     = CNT_LOAD;
                        w_ptr_nxt     = w_pick + IDW'(1);
                        w_state_nxt   = ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (r_cnt != '0) begin
                        w_cnt_nxt = r_cnt - CW'(1);
                    end else begin
                        w_oval_nxt  = 1'b1;
                        w_src_nxt   = r_sel;
                        w_state_nxt = ST_DELIVER;
                    end
                end
                ST_DELIVER: begin
                    if (out_ready[d]) begin
                        w_oval_nxt  = 1'b0;
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_ptr   <= '0;
                r_sel   <= '0;
                r_src   <= '0;
                r_oval  <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_ptr   <= w_ptr_nxt;
                r_sel   <= w_sel_nxt;
                r_src   <= w_src_nxt;
                r_oval  <= w_oval_nxt;
            end
        end

        assign w_port_grant[d] = w_gnt;
        assign out_sel[d]      = r_sel;
        assign out_src[d]      = r_src;
        assign out_valid[d]    = r_oval;
        assign port_busy[d]    = (r_state != ST_IDLE);
    end

    // Each source targets one port, so the per-port grant rows never overlap.
    always_comb begin
        w_grant_nxt = '0;
        for (int d = 0; d < NUM_PROC; d++) begin
            w_grant_nxt = w_grant_nxt | w_port_grant[d];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant <= '0;
        end else begin
            r_grant <= w_grant_nxt;
        end
    end

    always_comb begin
        w_in_flight = '0;
        for (int d = 0; d < NUM_PROC; d++) begin
            w_in_flight = w_in_flight + FW'(port_busy[d]);
        end
    end

    assign grant     = r_grant;
    assign in_flight = w_in_flight;

endmodule
`default_nettype wire

// File: tb/tb_crossbar_port_scheduler.sv
`default_nettype none
// Testbench for crossbar_port_scheduler: directed scenarios plus randomized
// traffic compared against a timestamp-based reference model.
module tb_crossbar_port_scheduler;

    localparam int NP    = 4;
    localparam int XFER  = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [3:0]      req_valid = '0;
    logic [3:0][1:0] req_dest = '0;
    logic [3:0]      out_ready = '1;
    logic [3:0]      grant;
    logic [3:0][1:0] out_sel;
    logic [3:0]      out_valid;
    logic [3:0][1:0] out_src;
    logic [3:0]      port_busy;
    logic [2:0]      in_flight;

    logic [3:0]      req_valid_b = '0;
    logic [3:0][1:0] req_dest_b = '0;
    logic [3:0]      out_ready_b = '1;
    logic [3:0]      grant_b;
    logic [3:0][1:0] out_sel_b;
    logic [3:0]      out_valid_b;
    logic [3:0][1:0] out_src_b;
    logic [3:0]      port_busy_b;
    logic [2:0]      in_flight_b;

    int n_checks = 0;
    int n_fail   = 0;

    crossbar_port_scheduler #(.NUM_PROC(NP), .XFER_CYCLES(XFER)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_dest(req_dest),
        .grant(grant), .out_sel(out_sel), .out_valid(out_valid), .out_src(out_src),
        .out_ready(out_ready), .port_busy(port_busy), .in_flight(in_flight)
    );

    crossbar_port_scheduler #(.NUM_PROC(NP), .XFER_CYCLES(1)) dut_b (
        .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_dest(req_dest_b),
        .grant(grant_b), .out_sel(out_sel_b), .out_valid(out_valid_b), .out_src(out_src_b),
        .out_ready(out_ready_b), .port_busy(port_busy_b), .in_flight(in_flight_b)
    );

    always #5 clk = ~clk;

    // Reference model: each port remembers the edge it granted on; completion
    // appears XFER edges later and clears on the first later edge with ready.
    logic [3:0] m_grant = '0;
    logic [3:0] m_prev_grant = '0;
    bit         m_active [NP];
    bit         m_done   [NP];
    int         m_gedge  [NP];
    int         m_sel    [NP];
    int         m_src    [NP];
    int         m_ptr    [NP];
    int         n_edge = 0;

    task automatic model_edge();
        logic [3:0] ng;
        bit         found;
        int         s;
        n_edge++;
        m_prev_grant = m_grant;
        ng = '0;
        if (rst) begin
            for (int d = 0; d < NP; d++) begin
                m_active[d] = 0; m_done[d] = 0; m_gedge[d] = 0;
                m_sel[d] = 0; m_src[d] = 0; m_ptr[d] = 0;
            end
            m_grant = '0;
            return;
        end
        for (int d = 0; d < NP; d++) begin
            if (m_active[d]) begin
                if (m_done[d]) begin
                    if (out_ready[d]) begin
                        m_active[d] = 0;
                        m_done[d]   = 0;
                    end
                end else if (n_edge - m_gedge[d] == XFER) begin
                    m_done[d] = 1;
                    m_src[d]  = m_sel[d];
                end
            end else begin
                found = 0;
                for (int k = 0; k < NP; k++) begin
                    s = (m_ptr[d] + k) % NP;
                    if (!found && req_valid[s] && int'(req_dest[s]) == d && !m_grant[s]) begin
                        found       = 1;
                        ng[s]       = 1'b1;
                        m_sel[d]    = s;
                        m_ptr[d]    = (s + 1) % NP;
                        m_active[d] = 1;
                        m_done[d]   = 0;
                        m_gedge[d]  = n_edge;
                    end
                end
            end
        end
        m_grant = ng;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0; req_valid_b = '0;
        out_ready = '1; out_ready_b = '1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        n_checks++;
        if (grant !== 4'b0 || out_valid !== 4'b0 || port_busy !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: grant=%b out_valid=%b port_busy=%b expected all 0", grant, out_valid, port_busy);
        end
        n_checks++;
        if (in_flight !== 3'd0 || out_sel !== 8'h00 || out_src !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_data: in_flight=%0d out_sel=%h out_src=%h expected 0", in_flight, out_sel, out_src);
        end
        n_checks++;
        if (grant_b !== 4'b0 || out_valid_b !== 4'b0 || in_flight_b !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_b: grant=%b out_valid=%b in_flight=%0d expected 0", grant_b, out_valid_b, in_flight_b);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        req_valid = 4'b0010; req_dest[1] = 2'd2;
        tick();
        n_checks++;
        if (grant !== 4'b0010 || port_busy !== 4'b0100 || in_flight !== 3'd1 || out_sel[2] !== 2'd1) begin
            n_fail++;
            $display("FAIL single_grant: grant=%b busy=%b in_flight=%0d sel2=%0d expected 0010 0100 1 1", grant, port_busy, in_flight, out_sel[2]);
        end
        tick();
        req_valid = '0;
        n_checks++;
        if (grant !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_one_cycle: grant=%b expected 0000", grant);
        end
        tick(); tick();
        n_checks++;
        if (out_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_early: out_valid=%b expected 0000", out_valid);
        end
        tick();
        n_checks++;
        if (out_valid !== 4'b0100 || out_src[2] !== 2'd1 || in_flight !== 3'd1) begin
            n_fail++;
            $display("FAIL single_done: out_valid=%b src2=%0d in_flight=%0d expected 0100 1 1", out_valid, out_src[2], in_flight);
        end
        tick();
        n_checks++;
        if (out_valid !== 4'b0000 || port_busy !== 4'b0000 || in_flight !== 3'd0) begin
            n_fail++;
            $display("FAIL single_idle: out_valid=%b busy=%b in_flight=%0d expected 0", out_valid, port_busy, in_flight);
        end
    endtask

    task automatic test_round_robin();
        int         seq [4] = '{0, 1, 3, 0};
        logic [3:0] exp;
        do_reset();
        req_valid = 4'b1011;
        req_dest[0] = 2'd2; req_dest[1] = 2'd2; req_dest[3] = 2'd2;
        for (int c = 0; c < 19; c++) begin
            tick();
            exp = (c % 6 == 0) ? 4'(1 << seq[c / 6]) : 4'b0000;
            n_checks++;
            if (grant !== exp) begin
                n_fail++;
                $display("FAIL rr_order c=%0d: grant=%b expected %b", c, grant, exp);
            end
        end
        req_valid = '0;
    endtask

    task automatic test_concurrent();
        do_reset();
        req_valid = 4'b0101; req_dest[0] = 2'd1; req_dest[2] = 2'd3;
        tick();
        n_checks++;
        if (grant !== 4'b0101 || in_flight !== 3'd2 || port_busy !== 4'b1010) begin
            n_fail++;
            $display("FAIL conc_grant: grant=%b in_flight=%0d busy=%b expected 0101 2 1010", grant, in_flight, port_busy);
        end
        tick();
        req_valid = '0;
        tick(); tick(); tick();
        n_checks++;
        if (out_valid !== 4'b1010 || out_src[1] !== 2'd0 || out_src[3] !== 2'd2) begin
            n_fail++;
            $display("FAIL conc_done: out_valid=%b src1=%0d src3=%0d expected 1010 0 2", out_valid, out_src[1], out_src[3]);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 4'b0000;
        req_valid = 4'b0010; req_dest[1] = 2'd2;
        tick();
        tick();
        req_valid = 4'b0001; req_dest[0] = 2'd2;
        tick(); tick(); tick();
        n_checks++;
        if (out_valid !== 4'b0100) begin
            n_fail++;
            $display("FAIL bp_valid: out_valid=%b expected 0100", out_valid);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if (out_valid !== 4'b0100 || out_src[2] !== 2'd1 || grant !== 4'b0000) begin
                n_fail++;
                $display("FAIL bp_hold i=%0d: out_valid=%b src2=%0d grant=%b expected 0100 1 0000", i, out_valid, out_src[2], grant);
            end
        end
        out_ready = 4'b1111;
        tick();
        n_checks++;
        if (grant !== 4'b0000 || out_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL bp_release: grant=%b out_valid=%b expected 0000 0000", grant, out_valid);
        end
        tick();
        n_checks++;
        if (grant !== 4'b0001) begin
            n_fail++;
            $display("FAIL bp_regrant: grant=%b expected 0001", grant);
        end
        req_valid = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_valid = 4'b0010; req_dest[1] = 2'd2;
        tick();
        tick();
        req_valid = '0;
        rst = 1'b1;
        tick();
        n_checks++;
        if (grant !== 4'b0 || port_busy !== 4'b0 || out_valid !== 4'b0 || in_flight !== 3'd0
            || out_sel !== 8'h00 || out_src !== 8'h00) begin
            n_fail++;
            $display("FAIL midrst_clear: grant=%b busy=%b valid=%b in_flight=%0d sel=%h src=%h expected 0",
                     grant, port_busy, out_valid, in_flight, out_sel, out_src);
        end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_checks++;
            if (out_valid !== 4'b0 || port_busy !== 4'b0) begin
                n_fail++;
                $display("FAIL midrst_dropped i=%0d: out_valid=%b busy=%b expected 0", i, out_valid, port_busy);
            end
        end
        req_valid = 4'b1001; req_dest[0] = 2'd2; req_dest[3] = 2'd2;
        tick();
        n_checks++;
        if (grant !== 4'b0001) begin
            n_fail++;
            $display("FAIL midrst_ptr: grant=%b expected 0001", grant);
        end
        req_valid = '0;
    endtask

    task automatic test_xfer1_self();
        do_reset();
        req_valid_b = 4'b1000; req_dest_b[3] = 2'd3;
        tick();
        n_checks++;
        if (grant_b !== 4'b1000 || port_busy_b !== 4'b1000 || out_sel_b[3] !== 2'd3) begin
            n_fail++;
            $display("FAIL x1_grant: grant=%b busy=%b sel3=%0d expected 1000 1000 3", grant_b, port_busy_b, out_sel_b[3]);
        end
        req_valid_b = '0;
        tick();
        n_checks++;
        if (out_valid_b !== 4'b1000 || out_src_b[3] !== 2'd3 || grant_b !== 4'b0000) begin
            n_fail++;
            $display("FAIL x1_done: out_valid=%b src3=%0d grant=%b expected 1000 3 0000", out_valid_b, out_src_b[3], grant_b);
        end
        tick();
        n_checks++;
        if (out_valid_b !== 4'b0000 || port_busy_b !== 4'b0000) begin
            n_fail++;
            $display("FAIL x1_idle: out_valid=%b busy=%b expected 0000 0000", out_valid_b, port_busy_b);
        end
    endtask

    task automatic test_random();
        int         qd [NP][4];
        int         qn [NP];
        logic [3:0] e_busy, e_valid;
        int         e_cnt;
        do_reset();
        for (int s = 0; s < NP; s++) qn[s] = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int s = 0; s < NP; s++) begin
                req_valid[s] = (qn[s] > 0);
                req_dest[s]  = (qn[s] > 0) ? 2'(qd[s][0]) : 2'($urandom);
            end
            out_ready = 4'($urandom) | 4'($urandom);
            tick();
            e_busy = '0; e_valid = '0; e_cnt = 0;
            for (int d = 0; d < NP; d++) begin
                e_busy[d]  = m_active[d];
                e_valid[d] = m_done[d];
                if (m_active[d]) e_cnt++;
            end
            n_checks++;
            if (grant !== m_grant || port_busy !== e_busy || out_valid !== e_valid || in_flight !== 3'(e_cnt)) begin
                n_fail++;
                $display("FAIL rand_ctrl cyc=%0d: grant=%b/%b busy=%b/%b valid=%b/%b in_flight=%0d/%0d (got/exp)",
                         cyc, grant, m_grant, port_busy, e_busy, out_valid, e_valid, in_flight, e_cnt);
            end
            for (int d = 0; d < NP; d++) begin
                if (m_active[d]) begin
                    n_checks++;
                    if (out_sel[d] !== 2'(m_sel[d])) begin
                        n_fail++;
                        $display("FAIL rand_sel cyc=%0d d=%0d: got %0d expected %0d", cyc, d, out_sel[d], m_sel[d]);
                    end
                end
                if (m_done[d]) begin
                    n_checks++;
                    if (out_src[d] !== 2'(m_src[d])) begin
                        n_fail++;
                        $display("FAIL rand_src cyc=%0d d=%0d: got %0d expected %0d", cyc, d, out_src[d], m_src[d]);
                    end
                end
            end
            for (int s = 0; s < NP; s++) begin
                if (m_prev_grant[s] && qn[s] > 0) begin
                    for (int k = 0; k < 3; k++) qd[s][k] = qd[s][k+1];
                    qn[s]--;
                end
                if (qn[s] < 4 && $urandom_range(0, 3) == 0) begin
                    qd[s][qn[s]] = int'($urandom_range(0, NP - 1));
                    qn[s]++;
                end
            end
        end
        req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_concurrent();
        test_backpressure();
        test_reset_mid();
        test_xfer1_self();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
